counter_ctrl: RTL

Sequencing controller for the 8-bit parallel-load counter. It accepts a count job (start value, stop value, prescale, mode) over a valid/ready handshake and drives the counter's `enable`, `load` and `d` inputs. It watches the counter's `q` and raises a terminal-count pulse, either finishing (one-shot) or reloading (periodic). It sits between the host/config logic and one counter instance.

---
 rtl/counter_ctrl_pkg.sv | 26 ++
 rtl/counter_ctrl_prescaler.sv | 34 +++
 rtl/counter_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter sequencing controller
package counter_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int PRESCALE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] start;
    logic [WIDTH_DEFAULT-1:0] stop;
    logic [PRESCALE_W-1:0]    prescale;
    logic                     periodic;
  } ctrl_job_t;

  // IDLE and DONE are the only states that take a new job.
  function automatic logic accepts_job(input ctrl_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// rtl/counter_ctrl_prescaler.sv - tick divider: counts 0..limit while running, holds on halt
module counter_ctrl_prescaler
  import counter_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  halt,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic                  at_limit;

  assign at_limit = (count_q == limit);
  assign tick     = run && !halt && at_limit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && !halt) begin
      if (at_limit) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - counter job sequencer; COUNTER_CTRL_PRESCALE_EN enables the tick prescaler
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_stop,
  input  logic [7:0]       cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             halt,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_enable,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_d,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  ctrl_state_t state_q, state_d;
  ctrl_job_t   job_q;
  logic        accept;
  logic        tick;
  logic        terminal;

  assign accept   = cfg_valid && cfg_ready;
  assign terminal = (cnt_q == WIDTH'(job_q.stop));

`ifdef COUNTER_CTRL_PRESCALE_EN
  counter_ctrl_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_LOAD),
    .run   (state_q == ST_RUN),
    .halt  (halt),
    .limit (job_q.prescale),
    .tick  (tick)
  );
`else
  logic unused_prescale;

  assign tick            = (state_q == ST_RUN) && !halt;
  assign unused_prescale = ^{cfg_prescale, job_q.prescale};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job fields only change on acceptance, so a request while busy leaves them alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      job_q <= '0;
    end else if (accept) begin
      job_q.start    <= WIDTH_DEFAULT'(cfg_start);
      job_q.stop     <= WIDTH_DEFAULT'(cfg_stop);
`ifdef COUNTER_CTRL_PRESCALE_EN
      job_q.prescale <= cfg_prescale;
`else
      job_q.prescale <= '0;
`endif
      job_q.periodic <= cfg_periodic;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_ready  = accepts_job(state_q) && !abort;
    cnt_enable = 1'b0;
    cnt_load   = 1'b0;
    cnt_d      = '0;
    tc_pulse   = 1'b0;
    busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done       = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_d    = WIDTH'(job_q.start);
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // Abort suppresses every tick-side effect, including the terminal strobe.
        if (tick && !abort) begin
          if (terminal) begin
            tc_pulse = 1'b1;
            if (job_q.periodic) begin
              cnt_load = 1'b1;
              cnt_d    = WIDTH'(job_q.start);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
    end
  end

endmodule
